// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer with load forwarding between MEM stage and data bus
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  input  logic              req_re,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = ADDR_W - 2;

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t            state_q, state_d;
  logic [WA-1:0]     ent_addr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              load_req, load_miss, full;
  logic              can_enq, enq, deq;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  // Walk oldest to youngest so the youngest matching entry overrides older ones.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) &&
          (ent_addr_q[rd_ptr_q + PW'(k)] == req_addr[ADDR_W-1:2])) begin
        hit      = 1'b1;
        hit_data = ent_data_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  assign load_req  = req_re && !req_we;
  assign load_miss = load_req && !hit;
  assign full      = (count_q == CW'(DEPTH));
  assign buf_empty = (count_q == '0) && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_stall = 1'b0;
    core_rdata = '0;
    can_enq    = 1'b0;
    deq        = 1'b0;
    enq        = 1'b0;
    case (state_q)
      IDLE: begin
        can_enq = 1'b1;
        if (load_miss) begin
          core_stall = 1'b1;
          state_d    = RD_REQ;
        end else if (count_q != '0) begin
          state_d = WR;
        end
      end
      WR: begin
        can_enq   = 1'b1;
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
        mem_wdata = ent_data_q[rd_ptr_q];
        if (load_miss) core_stall = 1'b1;
        if (mem_ready) begin
          deq     = 1'b1;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        core_stall = 1'b1;
        mem_valid  = 1'b1;
        mem_addr   = {req_addr[ADDR_W-1:2], 2'b00};
        if (mem_ready) begin
          if (mem_rvalid) begin
            rdata_d = mem_rdata;
            state_d = RD_DONE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        core_stall = 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        core_rdata = rdata_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a store in the cycle its head drains.
    enq = can_enq && req_we && (!full || deq);
    if (can_enq && req_we && !enq) core_stall = 1'b1;
    if (state_q != RD_DONE && load_req && hit) core_rdata = hit_data;

    count_d = count_q;
    if (enq && !deq) count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr_q[wr_ptr_q] <= req_addr[ADDR_W-1:2];
      ent_data_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(req_we && req_re));
  end

endmodule
